debounce_array: RTL

DEBOUNCE_ARRAY -- requirements
Module: debounce_array

---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_channel.sv | 81 ++++++++
 rtl/debounce_array.sv | 66 ++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and constants for the debounce_array block.
//   state_t             - per-channel FSM state (STABLE, PENDING)
//   DEFAULT_RESET_LEVEL - debounced level taken at reset (1 suits active-low buttons)
package debounce_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic DEFAULT_RESET_LEVEL = 1'b1;

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: single-channel debouncer FSM.
//   clk       - clock, all state on rising edge
//   reset     - synchronous active-high reset
//   sample_en - sampling strobe; state holds while low
//   s         - (possibly synchronised) raw input sample
//   dout      - registered debounced level
//   rise/fall - registered one-cycle pulses aligned with the dout change
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 5,
  parameter logic        RESET_LEVEL   = DEFAULT_RESET_LEVEL
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_en,
  input  logic s,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW   = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic          dout_nx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STABLE;
      count <= '0;
      dout  <= RESET_LEVEL;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      dout  <= dout_nx;
      // Pulses are derived from the same next-value so they line up with dout.
      rise  <= dout_nx & ~dout;
      fall  <= ~dout_nx & dout;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    dout_nx  = dout;
    if (sample_en) begin
      unique case (state)
        STABLE: begin
          if (s != dout) begin
            state_nx = PENDING;
            count_nx = CW'(1);
          end else begin
            count_nx = '0;
          end
        end
        PENDING: begin
          if (s == dout) begin
            state_nx = STABLE;
            count_nx = '0;
          end else if (count == LAST) begin
            dout_nx  = ~dout;
            state_nx = STABLE;
            count_nx = '0;
          end else begin
            count_nx = count + CW'(1);
          end
        end
        default: begin
          state_nx = STABLE;
          count_nx = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/debounce_array.sv
// debounce_array: N_CH independent input debouncers.
//   clk       - sole clock
//   reset     - synchronous active-high reset
//   sample_en - sampling strobe shared by all channels
//   Din       - raw bouncing inputs, one bit per channel
//   Dout      - registered debounced levels
//   rise/fall - one-cycle pulses on Dout 0->1 / 1->0
// Build option: define DEBOUNCE_SYNC_EN to insert a two-flop synchroniser on
// every Din bit (free-running, adds 2 cycles of latency).
module debounce_array
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = 4,
  parameter int unsigned STABLE_CYCLES = 5,
  parameter logic        RESET_LEVEL   = DEFAULT_RESET_LEVEL
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sample_en,
  input  logic [N_CH-1:0] Din,
  output logic [N_CH-1:0] Dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  if (N_CH == 0 || N_CH > 32 || STABLE_CYCLES < 2 || STABLE_CYCLES > 65535) begin : g_param_check
    $error("debounce_array: N_CH must be 1..32 and STABLE_CYCLES 2..65535");
  end

  logic [N_CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
  logic [N_CH-1:0] sync_meta, sync_out;

  // Clocked every cycle regardless of sample_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= {N_CH{RESET_LEVEL}};
      sync_out  <= {N_CH{RESET_LEVEL}};
    end else begin
      sync_meta <= Din;
      sync_out  <= sync_meta;
    end
  end

  assign s = sync_out;
`else
  assign s = Din;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .sample_en (sample_en),
      .s         (s[i]),
      .dout      (Dout[i]),
      .rise      (rise[i]),
      .fall      (fall[i])
    );
  end

endmodule
